ps2_host_tx: RTL and testbench
==============================

Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter. Sends one command byte (e.g. 0xF4 enable data reporting, 0xFF reset) from the FPGA to the mouse over the same PS2_CLK/PS2_DAT pair the mouse receiver listens on.
- Sits beside the ps2 receiver in the top level and drives the open-drain pins through pull-low enables.
- Its busy output gates the receiver so host frames are not decoded as mouse packets.

Parameters:
- INHIBIT_CYCLES, 5000: cycles clock is held low before the request (100 us at 50 MHz).
- REQ_CYCLES, 50: cycles clock and data are both held low before clock release (1 us).
- TIMEOUT_CYCLES, 750000: watchdog limit between device clock falling edges (15 ms).

Ports:
- clk  in  1  system clock (CLOCK_50).
- reset  in  1  asynchronous, active-high reset.
- send  in  1  one-cycle request; sampled only in IDLE.
- cmd  in  8  command byte; latched when send is accepted.
- ps2_clk_in  in  1  raw PS2_CLK pin level (asynchronous).
- ps2_dat_in  in  1  raw PS2_DAT pin level (asynchronous).
- ps2_clk_oe  out  1  1 = pull PS2_CLK low, 0 = release.
- ps2_dat_oe  out  1  1 = pull PS2_DAT low, 0 = release.
- busy  out  1  high from acceptance until return to IDLE.
- done  out  1  one-cycle pulse: frame acknowledged by device.
- error  out  1  one-cycle pulse: NACK or timeout.

Behaviour:
- Reset values: all outputs 0, state IDLE, counters 0. Reset mid-frame releases both lines immediately (asynchronous) and emits no done or error.
- Inputs pass through a 2-FF synchronizer. A falling edge is defined as synced clk previous=1, current=0. Edge detect lags the pin by 2-3 cycles.
- The byte is latched into a shift register with odd parity: par = ~^cmd.
- All outputs are registered. busy = (state != IDLE).
- IDLE: send=1 -> INHIBIT on the next cycle, with clk_oe=1 and busy=1 at cycle N+1. send while busy is ignored and the byte is not queued.
- INHIBIT: clk_oe=1, dat_oe=0 for INHIBIT_CYCLES cycles -> REQ.
- REQ: clk_oe=1, dat_oe=1 (start bit) for REQ_CYCLES cycles -> TX. Entering TX releases clk (clk_oe=0), keeps dat_oe=1, clears bit index and watchdog.
- TX: on each falling edge, advance the index and drive the next bit. Falling edges 1-8 drive D0..D7 LSB-first, edge 9 drives parity, edge 10 drives stop (released).
  - Bit encoding: dat_oe = ~bit, so 0 pulls low and 1 releases.
  - After edge 10 -> ACK.
- ACK: on falling edge 11, sample synced data.
  - Data 0 -> RECOVER with an ack-ok flag set.
  - Data 1 -> NACK: pulse error, then RECOVER with the flag clear.
- RECOVER: wait until synced clk=1 and data=1, then go to IDLE. Pulse done in that cycle only if ack-ok is set.
- Watchdog: cleared on TX entry and on every falling edge while in TX, ACK or RECOVER.
  - On reaching TIMEOUT_CYCLES-1: pulse error, release both lines, go to IDLE.
  - Timeout has priority over a falling edge in the same cycle.
- Exactly one of done or error pulses per accepted send. Neither pulses after a reset abort.
- Device clock edges during INHIBIT or REQ are ignored.
- Counter widths: $clog2 of each parameter. The bit index is 4 bits and saturates at 11.

Decomposition:
- Package ps2_def holds:
  - the state enum typedef {IDLE, INHIBIT, REQ, TX, ACK, RECOVER};
  - command constants PS2_CMD_RESET=8'hFF, PS2_CMD_ENABLE=8'hF4, PS2_CMD_SET_RATE=8'hF3;
  - the response constant PS2_RSP_ACK=8'hFA, which the receiver also uses.
- One sub-module, ps2_input_sync: 2-FF synchronizer plus falling-edge detector. The receiver reuses it.
- Top-level wiring:
  - PS2_CLK = ps2_clk_oe ? 1'b0 : 1'bz; PS2_DAT likewise.
  - busy holds off the receiver.

Test Plan (sim params: INHIBIT_CYCLES=20, REQ_CYCLES=4, TIMEOUT_CYCLES=200):
- Acknowledged frame: send with cmd=8'hF4, bench device clocks 11 edges with ack low on edge 11, then releases both lines.
  - Expect clk_oe high for 24 cycles, dat_oe high from cycle 21.
  - Bits D0..D7 = 0,0,1,0,1,1,1,1, parity=0 (dat_oe=1), stop released.
  - done pulses once, error stays 0, busy drops the same cycle.
- NACK: cmd=8'hFF, device leaves data high on edge 11 -> parity released (dat_oe=0), error pulses at edge 11, done never pulses, IDLE after lines go high.
- Timeout: device never clocks after REQ -> error pulses 200 cycles after TX entry, both oe=0, busy=0.
- Send while busy: second send with cmd=8'h00 during TX -> ignored, the transmitted byte is still 8'hF4, one done only.
- Reset mid-TX (after edge 5) -> clk_oe=dat_oe=busy=0 asynchronously, no done or error. A following send completes normally.
- Edge during INHIBIT: device clock toggles during INHIBIT -> ignored, bit index 0 at TX entry, frame still correct.

Source files
------------

// File: rtl/ps2_def.sv
// PS/2 shared definitions: FSM states, command bytes and the device response code.
// Imported by the host transmitter and by the mouse receiver.
package ps2_def;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQ,
        TX,
        ACK,
        RECOVER
    } state_e;

    localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
    localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] PS2_CMD_SET_RATE = 8'hF3;
    localparam logic [7:0] PS2_RSP_ACK      = 8'hFA;

    // Odd parity: the parity bit makes the total count of ones odd.
    function automatic logic odd_par(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/ps2_input_sync.sv
// Two-flop synchronizer for the PS/2 pins plus a falling-edge detector on clock.
// The edge pulse lags the pin by 2-3 system clocks.
module ps2_input_sync (
    input  logic clk_i,
    input  logic reset_i,
    input  logic ps2_clk_i,
    input  logic ps2_dat_i,
    output logic clk_s_o,
    output logic dat_s_o,
    output logic fall_o
);

    logic [1:0] s1_q;
    logic [1:0] s2_q;
    logic       prev_q;

    // Resolve metastability and remember the previous synced clock level.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            s1_q   <= 2'b11;
            s2_q   <= 2'b11;
            prev_q <= 1'b1;
        end else begin
            s1_q   <= {ps2_clk_i, ps2_dat_i};
            s2_q   <= s1_q;
            prev_q <= s2_q[1];
        end
    end

    assign clk_s_o = s2_q[1];
    assign dat_s_o = s2_q[0];
    assign fall_o  = prev_q & ~s2_q[1];

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, 11-bit frame, ack.
// Drives the open-drain pins through pull-low enables; all outputs registered.
module ps2_host_tx
    import ps2_def::*;
#(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int REQ_CYCLES     = 50,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       send,
    input  logic [7:0] cmd,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    output logic       busy,
    output logic       done,
    output logic       error
);

    localparam int DWI = $clog2(INHIBIT_CYCLES);
    localparam int DWR = $clog2(REQ_CYCLES);
    localparam int DW  = (DWI > DWR) ? DWI : DWR;
    localparam int WW  = $clog2(TIMEOUT_CYCLES);

    localparam logic [DW-1:0] INH_LAST = DW'(INHIBIT_CYCLES - 1);
    localparam logic [DW-1:0] REQ_LAST = DW'(REQ_CYCLES - 1);
    localparam logic [WW-1:0] WD_LAST  = WW'(TIMEOUT_CYCLES - 1);

    state_e        state_q, state_d;
    logic [DW-1:0] dly_q, dly_d;
    logic [WW-1:0] wd_q, wd_d;
    logic [3:0]    idx_q, idx_d;
    logic [8:0]    sh_q, sh_d;
    logic          ack_ok_q, ack_ok_d;
    logic          clk_oe_q, clk_oe_d;
    logic          dat_oe_q, dat_oe_d;
    logic          busy_q;
    logic          done_q, done_d;
    logic          error_q, error_d;

    logic clk_s;
    logic dat_s;
    logic fall;
    logic wd_live;
    logic [3:0] idx_inc;

    ps2_input_sync u_sync (
        .clk_i     (clk),
        .reset_i   (reset),
        .ps2_clk_i (ps2_clk_in),
        .ps2_dat_i (ps2_dat_in),
        .clk_s_o   (clk_s),
        .dat_s_o   (dat_s),
        .fall_o    (fall)
    );

    assign wd_live = (state_q == TX) || (state_q == ACK) || (state_q == RECOVER);
    assign idx_inc = (idx_q == 4'd11) ? idx_q : idx_q + 4'd1;

    // Next-state and next-output logic; the watchdog overrides everything else.
    always_comb begin
        state_d  = state_q;
        dly_d    = dly_q;
        wd_d     = wd_q;
        idx_d    = idx_q;
        sh_d     = sh_q;
        ack_ok_d = ack_ok_q;
        clk_oe_d = clk_oe_q;
        dat_oe_d = dat_oe_q;
        done_d   = 1'b0;
        error_d  = 1'b0;
        if (wd_live && (wd_q == WD_LAST)) begin
            state_d  = IDLE;
            clk_oe_d = 1'b0;
            dat_oe_d = 1'b0;
            wd_d     = '0;
            // A NACK already reported its error; do not report a second one.
            error_d  = (state_q != RECOVER) || ack_ok_q;
        end else begin
            if (wd_live) begin
                wd_d = fall ? '0 : wd_q + WW'(1);
            end
            unique case (state_q)
                IDLE: begin
                    if (send) begin
                        state_d  = INHIBIT;
                        sh_d     = {odd_par(cmd), cmd};
                        dly_d    = '0;
                        idx_d    = '0;
                        ack_ok_d = 1'b0;
                        clk_oe_d = 1'b1;
                        dat_oe_d = 1'b0;
                    end
                end
                INHIBIT: begin
                    if (dly_q == INH_LAST) begin
                        state_d  = REQ;
                        dly_d    = '0;
                        dat_oe_d = 1'b1;
                    end else begin
                        dly_d = dly_q + DW'(1);
                    end
                end
                REQ: begin
                    if (dly_q == REQ_LAST) begin
                        state_d  = TX;
                        dly_d    = '0;
                        idx_d    = '0;
                        wd_d     = '0;
                        clk_oe_d = 1'b0;
                    end else begin
                        dly_d = dly_q + DW'(1);
                    end
                end
                TX: begin
                    if (fall) begin
                        idx_d    = idx_inc;
                        dat_oe_d = ~sh_q[0];
                        // Ones shift in, so the tenth bit is the released stop bit.
                        sh_d     = {1'b1, sh_q[8:1]};
                        if (idx_q == 4'd9) begin
                            state_d = ACK;
                        end
                    end
                end
                ACK: begin
                    if (fall) begin
                        idx_d    = idx_inc;
                        state_d  = RECOVER;
                        ack_ok_d = ~dat_s;
                        error_d  = dat_s;
                    end
                end
                RECOVER: begin
                    if (clk_s && dat_s) begin
                        state_d = IDLE;
                        done_d  = ack_ok_q;
                    end
                end
                default: begin
                    state_d  = IDLE;
                    clk_oe_d = 1'b0;
                    dat_oe_d = 1'b0;
                end
            endcase
        end
    end

    // State, counters and registered outputs; reset releases both lines at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            dly_q    <= '0;
            wd_q     <= '0;
            idx_q    <= '0;
            sh_q     <= '0;
            ack_ok_q <= 1'b0;
            clk_oe_q <= 1'b0;
            dat_oe_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            dly_q    <= dly_d;
            wd_q     <= wd_d;
            idx_q    <= idx_d;
            sh_q     <= sh_d;
            ack_ok_q <= ack_ok_d;
            clk_oe_q <= clk_oe_d;
            dat_oe_q <= dat_oe_d;
            busy_q   <= (state_d != IDLE);
            done_q   <= done_d;
            error_q  <= error_d;
        end
    end

    assign ps2_clk_oe = clk_oe_q;
    assign ps2_dat_oe = dat_oe_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = error_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a simple open-drain device model.
// Covers ack, nack, timeout, send-while-busy, reset abort and inhibit glitches.
module tb_ps2_host_tx;

    logic       clk;
    logic       reset;
    logic       send;
    logic [7:0] cmd;
    logic       ps2_clk_in;
    logic       ps2_dat_in;
    logic       ps2_clk_oe;
    logic       ps2_dat_oe;
    logic       busy;
    logic       done;
    logic       error;

    logic dev_clk;
    logic dev_dat;
    logic glitch_en;
    logic glitch_val;

    int total;
    int bad;
    int cyc;
    int n_done;
    int n_err;
    int busy_bad;
    int err_cyc;
    int tx_cyc;
    logic clk_oe_prev;

    ps2_host_tx #(
        .INHIBIT_CYCLES (20),
        .REQ_CYCLES     (4),
        .TIMEOUT_CYCLES (200)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .send       (send),
        .cmd        (cmd),
        .ps2_clk_in (ps2_clk_in),
        .ps2_dat_in (ps2_dat_in),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_dat_oe (ps2_dat_oe),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    // Wired-AND bus: either side may pull low.
    assign ps2_clk_in = glitch_en ? glitch_val : (dev_clk & ~ps2_clk_oe);
    assign ps2_dat_in = dev_dat & ~ps2_dat_oe;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Pulse monitor, sampled on the inactive edge.
    always @(negedge clk) begin
        if (!reset) begin
            if (done) n_done++;
            if (error) begin
                n_err++;
                err_cyc = cyc;
            end
            if (done && busy) busy_bad++;
            if (busy && clk_oe_prev && !ps2_clk_oe) tx_cyc = cyc;
        end
        clk_oe_prev = ps2_clk_oe;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic run_frame(input logic [7:0] c, input logic [9:0] expv,
                             input bit ack, input bit glitch,
                             input bit bsend, input int abort_k);
        int oe_cnt;
        int first_dat;
        logic [9:0] bits;
        oe_cnt = 0;
        first_dat = 0;
        bits = '0;
        dev_clk = 1'b1;
        dev_dat = 1'b1;
        n_done = 0;
        n_err = 0;
        busy_bad = 0;
        send = 1'b1;
        cmd = c;
        tick();
        send = 1'b0;
        for (int i = 1; i <= 30; i++) begin
            if (ps2_clk_oe) oe_cnt++;
            if (ps2_dat_oe && first_dat == 0) first_dat = i;
            glitch_en = glitch && (i >= 3) && (i <= 14);
            glitch_val = i[0];
            tick();
        end
        glitch_en = 1'b0;
        chk("clk_oe_cycles", oe_cnt, 24);
        chk("dat_oe_first", first_dat, 21);
        chk("start_bit", {ps2_clk_oe, ps2_dat_oe, busy}, 3'b011);
        for (int k = 1; k <= 11; k++) begin
            if (k == 11) dev_dat = ~ack;
            dev_clk = 1'b0;
            repeat (6) tick();
            if (k <= 10) bits[k-1] = ps2_dat_oe;
            if (k == abort_k) begin
                #2 reset = 1'b1;
                #1;
                chk("abort_lines", {ps2_clk_oe, ps2_dat_oe, busy}, 3'b000);
                repeat (3) tick();
                reset = 1'b0;
                dev_clk = 1'b1;
                dev_dat = 1'b1;
                repeat (20) tick();
                chk("abort_pulses", {n_done[7:0], n_err[7:0]}, 16'h0000);
                chk("abort_idle", busy, 1'b0);
                return;
            end
            dev_clk = 1'b1;
            repeat (6) tick();
            if (bsend && k == 3) begin
                send = 1'b1;
                cmd = 8'h00;
                tick();
                send = 1'b0;
                cmd = c;
            end
        end
        dev_dat = 1'b1;
        for (int i = 0; i < 40 && busy; i++) tick();
        chk("back_idle", busy, 1'b0);
        chk("frame_bits", bits, expv);
        chk("done_cnt", n_done, ack ? 1 : 0);
        chk("err_cnt", n_err, ack ? 0 : 1);
        chk("done_busy", busy_bad, 0);
    endtask

    task automatic run_timeout();
        int t;
        t = 0;
        dev_clk = 1'b1;
        dev_dat = 1'b1;
        n_done = 0;
        n_err = 0;
        tx_cyc = -1;
        send = 1'b1;
        cmd = 8'hF3;
        tick();
        send = 1'b0;
        while (n_err == 0 && t < 400) begin
            tick();
            t++;
        end
        chk("to_seen", n_err, 1);
        chk("to_delay", err_cyc - tx_cyc, 200);
        chk("to_lines", {ps2_clk_oe, ps2_dat_oe, busy}, 3'b000);
        repeat (10) tick();
        chk("to_once", {n_done[7:0], n_err[7:0]}, 16'h0001);
    endtask

    initial begin
        total = 0;
        bad = 0;
        cyc = 0;
        n_done = 0;
        n_err = 0;
        busy_bad = 0;
        err_cyc = 0;
        tx_cyc = 0;
        reset = 1'b1;
        send = 1'b0;
        cmd = 8'h00;
        dev_clk = 1'b1;
        dev_dat = 1'b1;
        glitch_en = 1'b0;
        glitch_val = 1'b1;
        repeat (3) tick();
        chk("rst_out", {ps2_clk_oe, ps2_dat_oe, busy, done, error}, 5'b0);
        reset = 1'b0;
        repeat (3) tick();
        chk("idle_out", {ps2_clk_oe, ps2_dat_oe, busy, done, error}, 5'b0);
        // F4: D0..D7 = 0,0,1,0,1,1,1,1, parity 0 -> oe 1,1,0,1,0,0,0,0,1,0
        run_frame(8'hF4, 10'h10B, 1'b1, 1'b0, 1'b0, 0);
        // FF: all ones, parity 1 released, stop released
        run_frame(8'hFF, 10'h000, 1'b0, 1'b0, 1'b0, 0);
        run_timeout();
        run_frame(8'hF4, 10'h10B, 1'b1, 1'b0, 1'b1, 0);
        run_frame(8'h00, 10'h000, 1'b1, 1'b0, 1'b0, 5);
        run_frame(8'hF4, 10'h10B, 1'b1, 1'b0, 1'b0, 0);
        run_frame(8'hF4, 10'h10B, 1'b1, 1'b1, 1'b0, 0);
        // F3: 1,1,0,0,1,1,1,1 -> six ones, parity 1 released
        run_frame(8'hF3, 10'h00C, 1'b1, 1'b0, 1'b0, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
